// File: rtl/pwm_meter_pkg.sv
// ============================================================================
// pwm_meter_pkg
// Period constants and FSM state type shared by the PWM meter.
// Rev 1.0
// ============================================================================
`default_nettype none

package pwm_meter_pkg;

  localparam int DEF_RATIO    = 2;
  localparam int DEF_PWM_BITS = 3;

  typedef enum logic [0:0] {
    SEEK    = 1'b0,
    MEASURE = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_meter_tick_gen.sv
// ============================================================================
// tick_gen
// Free-running divider; one-clk sample tick every 2**RATIO cycles.
// Rev 1.0
// ============================================================================
`default_nettype none

module tick_gen #(
  parameter int RATIO = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [RATIO-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = &cnt;

endmodule

`default_nettype wire

// File: rtl/pwm_meter.sv
// ============================================================================
// pwm_meter
// Recovers the duty value of a PWM line, window locked to its rising edge.
// Rev 1.0
// ============================================================================
`default_nettype none

module pwm_meter
  import pwm_meter_pkg::*;
#(
  parameter int RATIO    = DEF_RATIO,
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pwm_in,
  output logic [PWM_BITS:0]   duty,
  output logic                duty_valid,
  output logic                locked,
  output logic                lock_err
);

  localparam int             CW        = PWM_BITS + 1;
  localparam logic [CW-1:0]  PERIOD    = CW'(2**PWM_BITS);
  localparam logic [CW-1:0]  LAST_SEEK = CW'(2**PWM_BITS - 1);
  localparam logic [CW-1:0]  ONE       = CW'(1);

  logic          tick;
  logic          sync1;
  logic          pwm_s;
  logic          pwm_q;
  logic          rise;
  state_t        state,   state_nx;
  logic [CW-1:0] win_cnt, win_nx;
  logic [CW-1:0] hi_cnt,  hi_nx;
  logic [CW-1:0] duty_nx;
  logic          valid_nx;
  logic          err_nx;

  tick_gen #(.RATIO(RATIO)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      pwm_s <= 1'b0;
      pwm_q <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      pwm_s <= sync1;
      if (tick) begin
        pwm_q <= pwm_s;
      end
    end
  end

  assign rise = tick & pwm_s & ~pwm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEEK;
      win_cnt    <= '0;
      hi_cnt     <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
      lock_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      win_cnt    <= win_nx;
      hi_cnt     <= hi_nx;
      duty       <= duty_nx;
      duty_valid <= valid_nx;
      lock_err   <= err_nx;
    end
  end

  // In SEEK, win_cnt doubles as the count of consecutive rise-free ticks.
  always_comb begin
    state_nx = state;
    win_nx   = win_cnt;
    hi_nx    = hi_cnt;
    duty_nx  = duty;
    valid_nx = 1'b0;
    err_nx   = 1'b0;
    if (tick) begin
      case (state)
        SEEK: begin
          if (rise) begin
            state_nx = MEASURE;
            win_nx   = ONE;
            hi_nx    = ONE;
          end else if (win_cnt == LAST_SEEK) begin
            duty_nx  = pwm_s ? PERIOD : '0;
            valid_nx = 1'b1;
            win_nx   = '0;
          end else begin
            win_nx = win_cnt + 1'b1;
          end
        end
        MEASURE: begin
          if (win_cnt == PERIOD) begin
            duty_nx  = hi_cnt;
            valid_nx = 1'b1;
            if (rise) begin
              win_nx = ONE;
              hi_nx  = ONE;
            end else begin
              // The boundary tick already counts as the first rise-free tick.
              state_nx = SEEK;
              win_nx   = ONE;
              hi_nx    = '0;
            end
          end else if (rise) begin
            err_nx = 1'b1;
            win_nx = ONE;
            hi_nx  = ONE;
          end else begin
            win_nx = win_cnt + 1'b1;
            hi_nx  = hi_cnt + {{PWM_BITS{1'b0}}, pwm_s};
          end
        end
        default: state_nx = SEEK;
      endcase
    end
  end

  assign locked = (state == MEASURE);

endmodule

`default_nettype wire

// File: tb/tb_pwm_meter.sv
// ============================================================================
// tb_pwm_meter
// Self-checking bench: directed vector table, corner sequences, random model.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pwm_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pwm_in = 1'b0;
  logic [3:0] duty;
  logic       duty_valid;
  logic       locked;
  logic       lock_err;

  pwm_meter dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .duty       (duty),
    .duty_valid (duty_valid),
    .locked     (locked),
    .lock_err   (lock_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d0;
    int d1;
    int exp_duty;
    int exp_locked;
  } vec_t;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int rel         = 0;
  int err_cnt     = 0;
  bit mon_en      = 1'b0;
  int got_q[$];
  int cyc_q[$];
  bit stim[$];
  int exp_q[$];
  int exp_err;

  function automatic void chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Report log: duty value and clk offset from reset release.
  always @(negedge clk) begin
    if (mon_en) begin
      if (duty_valid) begin
        got_q.push_back(int'(duty));
        cyc_q.push_back(cyc - rel);
      end
      if (lock_err) err_cnt++;
      chk("valid_err_exclusive", int'(duty_valid & lock_err), 0);
    end
  end

  task automatic add_period(input int d);
    for (int i = 0; i < 8; i++) stim.push_back(i < d);
  endtask

  task automatic start();
    @(negedge clk);
    mon_en = 1'b0;
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    got_q.delete();
    cyc_q.delete();
    err_cnt = 0;
    rst     = 1'b0;
    rel     = cyc;
    mon_en  = 1'b1;
  endtask

  // Each stim entry is the line level seen by one sample tick.
  task automatic play(input int lo, input int hi);
    for (int j = lo; j < hi; j++) begin
      pwm_in = stim[j];
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic stop();
    @(negedge clk);
    mon_en = 1'b0;
  endtask

  function automatic bit is_rise(input int t);
    return stim[t] && (t == 0 || !stim[t-1]);
  endfunction

  // Reference: walk the tick-sample stream, windows anchored on rising edges.
  function automatic void model();
    int n = stim.size();
    int t = 0;
    int quiet = 0;
    exp_q.delete();
    exp_err = 0;
    while (t < n) begin
      if (is_rise(t)) begin
        int r = -1;
        int s = 0;
        for (int k = 1; k < 8 && t + k < n; k++) begin
          if (is_rise(t + k)) begin
            r = t + k;
            break;
          end
        end
        if (r >= 0) begin
          exp_err++;
          t = r;
        end else if (t + 8 >= n) begin
          t = n;
        end else begin
          for (int k = 0; k < 8; k++) s += int'(stim[t + k]);
          exp_q.push_back(s);
          if (is_rise(t + 8)) begin
            t = t + 8;
          end else begin
            quiet = 1;
            t = t + 9;
          end
        end
      end else begin
        quiet++;
        if (quiet == 8) begin
          exp_q.push_back(stim[t] ? 8 : 0);
          quiet = 0;
        end
        t++;
      end
    end
  endfunction

  initial begin
    vec_t tbl[8];
    tbl[0] = '{3, 3, 3, 1};
    tbl[1] = '{3, 7, 7, 1};
    tbl[2] = '{5, 1, 1, 1};
    tbl[3] = '{0, 4, 4, 1};
    tbl[4] = '{0, 0, 0, 0};
    tbl[5] = '{8, 8, 8, 0};
    tbl[6] = '{1, 8, 8, 0};
    tbl[7] = '{7, 0, 0, 0};

    #2 rst = 1'b1;
    #1;
    chk("reset_duty", int'(duty), 0);
    chk("reset_valid", int'(duty_valid), 0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_lock_err", int'(lock_err), 0);

    // Constant low line from reset.
    start();
    stim.delete();
    repeat (2) add_period(0);
    play(0, 16);
    stop();
    chk("low_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("low_duty0", got_q[0], 0);
      chk("low_duty1", got_q[1], 0);
      chk("low_cyc0", cyc_q[0], 32);
      chk("low_cyc1", cyc_q[1], 64);
    end
    chk("low_locked", int'(locked), 0);

    // Steady 3/8 lock.
    start();
    stim.delete();
    repeat (4) add_period(3);
    play(0, 1);
    chk("lock_after_rise", int'(locked), 1);
    play(1, 32);
    stop();
    chk("lock3_count", got_q.size(), 3);
    foreach (got_q[i]) chk("lock3_duty", got_q[i], 3);
    if (cyc_q.size() == 3) begin
      chk("lock3_cyc0", cyc_q[0], 36);
      chk("lock3_gap", cyc_q[2] - cyc_q[1], 32);
    end
    chk("lock3_err", err_cnt, 0);
    chk("lock3_locked", int'(locked), 1);

    // Phase jump: extra rise at tick 5 of a window.
    start();
    stim.delete();
    repeat (2) add_period(3);
    for (int i = 0; i < 5; i++) stim.push_back(i < 3);
    repeat (3) add_period(3);
    play(0, stim.size());
    stop();
    chk("jump_err", err_cnt, 1);
    chk("jump_count", got_q.size(), 4);
    foreach (got_q[i]) chk("jump_duty", got_q[i], 3);
    if (cyc_q.size() == 4) chk("jump_gap", cyc_q[2] - cyc_q[1], 52);
    chk("jump_locked", int'(locked), 1);

    // Asynchronous reset mid-window.
    start();
    stim.delete();
    repeat (3) add_period(3);
    play(0, 20);
    chk("pre_rst_duty", int'(duty), 3);
    chk("pre_rst_locked", int'(locked), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_duty", int'(duty), 0);
    chk("rst_valid", int'(duty_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_lock_err", int'(lock_err), 0);
    mon_en = 1'b0;
    repeat (3) @(negedge clk);
    got_q.delete();
    cyc_q.delete();
    err_cnt = 0;
    rst     = 1'b0;
    rel     = cyc;
    mon_en  = 1'b1;
    play(0, 24);
    stop();
    chk("post_rst_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("post_rst_cyc0", cyc_q[0], 36);
      chk("post_rst_duty0", got_q[0], 3);
    end

    // Vector table: two periods at d0 then two at d1.
    for (int v = 0; v < 8; v++) begin
      start();
      stim.delete();
      repeat (2) add_period(tbl[v].d0);
      repeat (2) add_period(tbl[v].d1);
      play(0, 32);
      stop();
      chk("tbl_last_duty", (got_q.size() > 0) ? got_q[$] : -1, tbl[v].exp_duty);
      chk("tbl_locked", int'(locked), tbl[v].exp_locked);
      chk("tbl_lock_err", err_cnt, 0);
    end

    // Random duties against the reference model.
    start();
    stim.delete();
    for (int p = 0; p < 200; p++) add_period(int'($urandom_range(0, 8)));
    model();
    play(0, stim.size());
    stop();
    chk("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk("rand_duty", got_q[i], exp_q[i]);
    end
    chk("rand_lock_err", err_cnt, exp_err);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
